// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command decoder: opcode masks, FSM encodings,
// DDRAM line bases and the address helpers used by the decoder.
package lcd_pkg;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StExec  = 2'd1;
  localparam logic [1:0] StClear = 2'd2;
  localparam logic [1:0] StWait  = 2'd3;

  localparam logic [7:0] OpSetDdram = 8'h80;
  localparam logic [7:0] OpSetCgram = 8'h40;
  localparam logic [7:0] OpFuncSet  = 8'h20;
  localparam logic [7:0] OpShift    = 8'h10;
  localparam logic [7:0] OpDisplay  = 8'h08;
  localparam logic [7:0] OpEntry    = 8'h04;
  localparam logic [7:0] OpHome     = 8'h02;
  localparam logic [7:0] OpClear    = 8'h01;

  localparam logic [6:0] Line0Base = 7'h00;
  localparam logic [6:0] Line1Base = 7'h40;
  localparam logic [7:0] BlankChar = 8'h20;

  typedef enum logic [2:0] {
    InsNop, InsSetDdram, InsFuncSet, InsDisplay, InsEntry, InsHome, InsClear
  } ins_e;

  // Highest set bit wins; CGRAM and cursor-shift are accepted as no-ops.
  function automatic ins_e decode_ins(logic [7:0] d);
    if (|(d & OpSetDdram)) return InsSetDdram;
    if (|(d & OpSetCgram)) return InsNop;
    if (|(d & OpFuncSet))  return InsFuncSet;
    if (|(d & OpShift))    return InsNop;
    if (|(d & OpDisplay))  return InsDisplay;
    if (|(d & OpEntry))    return InsEntry;
    if (|(d & OpHome))     return InsHome;
    if (|(d & OpClear))    return InsClear;
    return InsNop;
  endfunction

  // Addresses beyond the 16 visible columns of a line snap to the other line's base.
  function automatic logic [6:0] map_ddram_addr(logic [6:0] a);
    if (a[5:4] == 2'b00) return a;
    return a[6] ? Line0Base : Line1Base;
  endfunction

  function automatic logic [6:0] ac_step(logic [6:0] ac, logic inc);
    if (inc) begin
      if (ac == 7'h0F) return Line1Base;
      if (ac == 7'h4F) return Line0Base;
      return ac + 7'd1;
    end
    if (ac == 7'h00) return 7'h4F;
    if (ac == 7'h40) return 7'h0F;
    return ac - 7'd1;
  endfunction

  function automatic logic [4:0] ddram_index(logic [6:0] ac);
    return {ac[6], ac[3:0]};
  endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 32x8 display data RAM: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module lcd_ddram (
  input  logic       clk,
  input  logic       i_we,
  input  logic [4:0] i_waddr,
  input  logic [7:0] i_wdata,
  input  logic [4:0] i_raddr,
  output logic [7:0] o_rdata
);

  logic [7:0] r_mem [32];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/lcd_cmd_decoder.sv
// HD44780-style bus slave: synchronises the E strobe, decodes instruction and data
// writes, maintains the address counter and DDRAM, and models the busy period.
module lcd_cmd_decoder
  import lcd_pkg::*;
#(
  parameter int unsigned CMD_BUSY  = 20,
  parameter int unsigned HOME_BUSY = 200
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_data,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       disp_on,
  output logic [6:0] ddram_addr,
  input  logic [4:0] char_rd_addr,
  output logic [7:0] char_rd_data,
  output logic       cmd_strobe,
  output logic       err_busy_wr
);

  // EXEC is the first busy cycle, so WAIT covers the remainder.
  localparam logic [15:0] CmdLoad  = 16'(CMD_BUSY - 1);
  localparam logic [15:0] HomeLoad = 16'(HOME_BUSY - 1);

  logic        r_e_s1, r_e_s2, r_e_s3;
  logic        r_cap_stb, r_cap_rs, r_cap_rw;
  logic [7:0]  r_cap_data;
  logic [1:0]  r_state;
  logic [6:0]  r_ac;
  logic        r_id, r_dl, r_n, r_disp_on, r_err;
  logic [15:0] r_cnt;
  logic [4:0]  r_clr_idx;

  logic        w_e_fall;
  logic [1:0]  w_state_nxt;
  logic [6:0]  w_ac_nxt;
  logic        w_id_nxt, w_dl_nxt, w_n_nxt, w_disp_nxt, w_err_nxt;
  logic [15:0] w_cnt_nxt;
  logic [4:0]  w_clr_nxt;
  logic        w_we;
  logic [4:0]  w_waddr;
  logic [7:0]  w_wdata;
  ins_e        w_ins;
  logic        w_unused_cfg;

  assign w_e_fall = r_e_s3 & ~r_e_s2;
  assign w_ins    = decode_ins(r_cap_data);

  always_comb begin
    w_state_nxt = r_state;
    w_ac_nxt    = r_ac;
    w_id_nxt    = r_id;
    w_dl_nxt    = r_dl;
    w_n_nxt     = r_n;
    w_disp_nxt  = r_disp_on;
    w_err_nxt   = r_err;
    w_cnt_nxt   = r_cnt;
    w_clr_nxt   = r_clr_idx;
    w_we        = 1'b0;
    w_waddr     = ddram_index(r_ac);
    w_wdata     = r_cap_data;

    if (r_cap_stb && !r_cap_rw && (r_state != StIdle)) w_err_nxt = 1'b1;

    unique case (r_state)
      StIdle: begin
        if (r_cap_stb && !r_cap_rw) w_state_nxt = StExec;
      end
      StExec: begin
        w_state_nxt = StWait;
        w_cnt_nxt   = CmdLoad;
        if (r_cap_rs) begin
          w_we     = 1'b1;
          w_ac_nxt = ac_step(r_ac, r_id);
        end else begin
          case (w_ins)
            InsSetDdram: w_ac_nxt   = map_ddram_addr(r_cap_data[6:0]);
            InsFuncSet: begin
              w_dl_nxt = r_cap_data[4];
              w_n_nxt  = r_cap_data[3];
            end
            InsDisplay:  w_disp_nxt = r_cap_data[2];
            InsEntry:    w_id_nxt   = r_cap_data[1];
            InsHome: begin
              w_ac_nxt  = Line0Base;
              w_cnt_nxt = HomeLoad;
            end
            InsClear: begin
              w_state_nxt = StClear;
              w_clr_nxt   = 5'd0;
            end
            default: ;
          endcase
        end
      end
      StClear: begin
        w_we      = 1'b1;
        w_waddr   = r_clr_idx;
        w_wdata   = BlankChar;
        w_clr_nxt = r_clr_idx + 5'd1;
        if (r_clr_idx == 5'd31) begin
          w_ac_nxt    = Line0Base;
          w_id_nxt    = 1'b1;
          w_cnt_nxt   = CmdLoad;
          w_state_nxt = StWait;
        end
      end
      StWait: begin
        if (r_cnt <= 16'd1) w_state_nxt = StIdle;
        else                w_cnt_nxt   = r_cnt - 16'd1;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_e_s1     <= 1'b0;
      r_e_s2     <= 1'b0;
      r_e_s3     <= 1'b0;
      r_cap_stb  <= 1'b0;
      r_cap_rs   <= 1'b0;
      r_cap_rw   <= 1'b0;
      r_cap_data <= 8'h00;
      r_state    <= StIdle;
      r_ac       <= Line0Base;
      r_id       <= 1'b1;
      r_dl       <= 1'b1;
      r_n        <= 1'b1;
      r_disp_on  <= 1'b0;
      r_err      <= 1'b0;
      r_cnt      <= 16'd0;
      r_clr_idx  <= 5'd0;
    end else begin
      r_e_s1    <= lcd_e;
      r_e_s2    <= r_e_s1;
      r_e_s3    <= r_e_s2;
      r_cap_stb <= w_e_fall;
      if (w_e_fall) begin
        r_cap_rs   <= lcd_rs;
        r_cap_rw   <= lcd_rw;
        r_cap_data <= lcd_data;
      end
      r_state   <= w_state_nxt;
      r_ac      <= w_ac_nxt;
      r_id      <= w_id_nxt;
      r_dl      <= w_dl_nxt;
      r_n       <= w_n_nxt;
      r_disp_on <= w_disp_nxt;
      r_err     <= w_err_nxt;
      r_cnt     <= w_cnt_nxt;
      r_clr_idx <= w_clr_nxt;
    end
  end

  lcd_ddram u_ddram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (char_rd_addr),
    .o_rdata (char_rd_data)
  );

  // Interface width and line count are held as state but drive no logic here.
  assign w_unused_cfg = ^{r_dl, r_n};

  assign busy        = (r_state != StIdle);
  assign cmd_strobe  = (r_state == StExec);
  assign rd_data     = {busy, r_ac};
  assign ddram_addr  = r_ac;
  assign disp_on     = r_disp_on;
  assign err_busy_wr = r_err;

endmodule

// File: tb/tb_lcd_cmd_decoder.sv
// Randomised self-checking bench for lcd_cmd_decoder against a line/column
// model of the display controller.
module tb_lcd_cmd_decoder;

  localparam int unsigned CmdBusy  = 6;
  localparam int unsigned HomeBusy = 15;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       lcd_e = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
  logic [7:0] lcd_data = 8'h00;
  logic [4:0] char_rd_addr = 5'd0;
  logic [7:0] rd_data, char_rd_data;
  logic [6:0] ddram_addr;
  logic       busy, disp_on, cmd_strobe, err_busy_wr;

  lcd_cmd_decoder #(
    .CMD_BUSY  (CmdBusy),
    .HOME_BUSY (HomeBusy)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .lcd_e        (lcd_e),
    .lcd_rs       (lcd_rs),
    .lcd_rw       (lcd_rw),
    .lcd_data     (lcd_data),
    .rd_data      (rd_data),
    .busy         (busy),
    .disp_on      (disp_on),
    .ddram_addr   (ddram_addr),
    .char_rd_addr (char_rd_addr),
    .char_rd_data (char_rd_data),
    .cmd_strobe   (cmd_strobe),
    .err_busy_wr  (err_busy_wr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Busy-period and strobe monitor.
  int busy_run = 0, last_run = 0, strobe_cnt = 0;
  always @(negedge clk) begin
    if (cmd_strobe) strobe_cnt++;
    if (busy) busy_run++;
    else if (busy_run != 0) begin
      last_run = busy_run;
      busy_run = 0;
    end
  end

  // Reference model: cursor as (line, column), memory as 2x16 characters.
  int         m_line = 0, m_col = 0;
  bit         m_inc = 1'b1, m_disp = 1'b0;
  logic [7:0] m_mem [32];
  bit         m_known [32];

  function automatic int m_ac();
    return m_line * 64 + m_col;
  endfunction

  function automatic int hi_bit(logic [7:0] d);
    for (int i = 7; i >= 0; i--) if (d[i]) return i;
    return -1;
  endfunction

  task automatic model_write(input bit rs, input logic [7:0] d, output int busy_exp);
    int a;
    busy_exp = CmdBusy;
    if (rs) begin
      m_mem[m_line * 16 + m_col]   = d;
      m_known[m_line * 16 + m_col] = 1'b1;
      if (m_inc) begin
        m_col++;
        if (m_col == 16) begin m_col = 0; m_line ^= 1; end
      end else if (m_col == 0) begin
        m_col = 15; m_line ^= 1;
      end else m_col--;
    end else begin
      case (hi_bit(d))
        7: begin
          a = int'(d[6:0]);
          if (a < 16)      begin m_line = 0; m_col = a;      end
          else if (a < 64) begin m_line = 1; m_col = 0;      end
          else if (a < 80) begin m_line = 1; m_col = a - 64; end
          else             begin m_line = 0; m_col = 0;      end
        end
        3: m_disp = d[2];
        2: m_inc  = d[1];
        1: begin m_line = 0; m_col = 0; busy_exp = HomeBusy; end
        0: begin
          for (int i = 0; i < 32; i++) begin m_mem[i] = 8'h20; m_known[i] = 1'b1; end
          m_line = 0; m_col = 0; m_inc = 1'b1;
          busy_exp = 32 + CmdBusy;
        end
        default: ;
      endcase
    end
  endtask

  task automatic bus_drop(input bit rs, input bit rw, input logic [7:0] d);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_e = 1'b1;
    repeat (2) @(negedge clk);
    lcd_e = 1'b0;
  endtask

  task automatic do_write(input bit rs, input logic [7:0] d);
    int exp_busy, lat;
    bit seen;
    model_write(rs, d, exp_busy);
    bus_drop(rs, 1'b0, d);
    seen = 1'b0; lat = 0;
    for (int i = 1; i <= 10 && !seen; i++) begin
      @(negedge clk);
      if (cmd_strobe) begin seen = 1'b1; lat = i; end
    end
    check("strobe_latency", lat, 4);
    repeat (exp_busy + 2) @(negedge clk);
    check("busy_len", last_run, exp_busy);
    check("ac", {25'd0, ddram_addr}, m_ac());
    check("rd_data", {24'd0, rd_data}, {24'd0, 1'b0, 7'(m_ac())});
  endtask

  task automatic check_char(input int idx);
    char_rd_addr = 5'(idx);
    #1;
    if (m_known[idx]) check($sformatf("char[%0d]", idx), {24'd0, char_rd_data}, {24'd0, m_mem[idx]});
  endtask

  task automatic check_reset_state();
    check("rst_rd_data", {24'd0, rd_data}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_ac", {25'd0, ddram_addr}, 0);
    check("rst_disp_on", {31'd0, disp_on}, 0);
    check("rst_strobe", {31'd0, cmd_strobe}, 0);
    check("rst_err", {31'd0, err_busy_wr}, 0);
  endtask

  initial begin
    int op, eb;
    logic [7:0] d;
    for (int i = 0; i < 32; i++) begin m_mem[i] = 8'h00; m_known[i] = 1'b0; end

    repeat (3) @(negedge clk);
    check_reset_state();
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    // Power-up sequence.
    strobe_cnt = 0;
    do_write(1'b0, 8'h3C);
    do_write(1'b0, 8'h06);
    do_write(1'b0, 8'h0C);
    do_write(1'b1, 8'h41);
    check("disp_on", {31'd0, disp_on}, {31'd0, m_disp});
    check("strobe_count", strobe_cnt, 4);
    check_char(0);

    // Status read leaves the FSM untouched.
    bus_drop(1'b0, 1'b1, 8'hFF);
    repeat (10) @(negedge clk);
    check("read_no_strobe", strobe_cnt, 4);
    check("read_no_busy", last_run, CmdBusy);

    // Line wrap on increment.
    do_write(1'b0, 8'h8F);
    do_write(1'b1, 8'h78);
    do_write(1'b1, 8'h79);
    check_char(15);
    check_char(16);

    // Decrement wrap from line 1 back to line 0.
    do_write(1'b0, 8'h04);
    do_write(1'b0, 8'hC0);
    do_write(1'b1, 8'h7A);
    check_char(16);

    do_write(1'b0, 8'h02);
    do_write(1'b0, 8'h01);
    for (int i = 0; i < 32; i++) check_char(i);

    // Random mix of data writes and instructions.
    for (int n = 0; n < 40; n++) begin
      op = int'($urandom_range(0, 9));
      d  = 8'($urandom);
      if (op <= 5)      do_write(1'b1, d);
      else if (op == 6) do_write(1'b0, 8'h80 | d);
      else if (op == 7) do_write(1'b0, 8'h04 | (d & 8'h03));
      else if (op == 8) do_write(1'b0, 8'h08 | (d & 8'h07));
      else              do_write(1'b0, d);
      check("rand_disp_on", {31'd0, disp_on}, {31'd0, m_disp});
      check_char(int'($urandom_range(0, 31)));
    end
    for (int i = 0; i < 32; i++) check_char(i);

    // Write landing one cycle after a prior write's strobe is dropped.
    do_write(1'b0, 8'h06);
    do_write(1'b0, 8'h80);
    do_write(1'b1, 8'h11);
    do_write(1'b1, 8'h22);
    do_write(1'b0, 8'h80);
    strobe_cnt = 0;
    model_write(1'b1, 8'h70, eb);
    @(negedge clk);
    lcd_rs = 1'b1; lcd_rw = 1'b0; lcd_data = 8'h70; lcd_e = 1'b1;
    repeat (2) @(negedge clk);
    lcd_e = 1'b0;
    @(negedge clk);
    lcd_e = 1'b1;
    @(negedge clk);
    lcd_e = 1'b0;
    repeat (CmdBusy + 10) @(negedge clk);
    check("err_busy_wr", {31'd0, err_busy_wr}, 1);
    check("drop_strobes", strobe_cnt, 1);
    check("drop_ac", {25'd0, ddram_addr}, m_ac());
    check_char(0);
    check_char(1);

    // Reset in the middle of a clear.
    bus_drop(1'b0, 1'b0, 8'h01);
    repeat (14) @(negedge clk);
    resetn = 1'b0;
    for (int i = 0; i < 32; i++) m_known[i] = 1'b0;
    m_line = 0; m_col = 0; m_inc = 1'b1; m_disp = 1'b0;
    @(negedge clk);
    check_reset_state();
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    do_write(1'b0, 8'h01);
    for (int i = 0; i < 32; i++) check_char(i);
    do_write(1'b1, 8'h5A);
    check_char(0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
